gshare_pht: RTL and testbench
=============================

// Module: gshare_pht
// PURPOSE
//   Gshare pattern-history table of 2-bit saturating counters that feeds the fetch-stage
//   branch prediction and is trained by the execute-stage branch resolution.
//   A lookup hashes the PC with a global history register (GHR) to select a counter, and
//   returns a registered taken/not-taken prediction plus the table index used.
//   The resolution stage later returns that index with the actual outcome to train the
//   counter and shift the GHR.
// PARAMETERS
//   PC_W       32  PC width in bits
//   IDX_BITS    6  log2(table entries); 64 counters by default
//   HIST_BITS   4  GHR length; must be 1..IDX_BITS
// PORTS
//   clk            in   1         clock; all state updates on rising edge
//   reset          in   1         synchronous, active-low reset
//   lookup_valid   in   1         fetch requests a prediction this cycle
//   lookup_pc      in   PC_W      PC of the branch being fetched
//   pred_valid     out  1         prediction below is valid (1 cycle after lookup_valid)
//   prediction     out  1         1 = predict taken (counter MSB)
//   pred_index     out  IDX_BITS  table index used; carried down the pipe to update_index
//   update_valid   in   1         resolved branch this cycle
//   update_index   in   IDX_BITS  index returned from pred_index of that branch
//   update_taken   in   1         actual outcome of the resolved branch
//   ghr            out  HIST_BITS current global history (debug/trace)
// BEHAVIOUR
//   Reset (reset==0 at a clk edge): every counter <= 2'b01 (weakly not-taken);
//     ghr <= 0; pred_valid <= 0; prediction <= 0; pred_index <= 0.
//     Completes in one cycle; all lookups and updates that cycle are dropped.
//     Reset mid-stream discards any pending prediction.
//   Index hash: idx = lookup_pc[IDX_BITS+1:2] ^ {{(IDX_BITS-HIST_BITS){1'b0}}, ghr};
//     PC bits [1:0] are ignored; ghr is the value before this edge.
//   Lookup, latency 1: on edge with lookup_valid=1: pred_valid<=1, pred_index<=idx,
//     prediction<=table[idx][1]. With lookup_valid=0: pred_valid<=0, while
//     prediction and pred_index hold their previous values.
//   Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//   Update on edge with update_valid=1:
//     - taken:     table[update_index] <= (cnt==2'b11) ? 2'b11 : cnt+1
//     - not taken: table[update_index] <= (cnt==2'b00) ? 2'b00 : cnt-1
//     - Counters saturate and never wrap.
//     - ghr <= {ghr[HIST_BITS-2:0], update_taken}; for HIST_BITS==1, ghr <= update_taken.
//   Same-edge lookup and update:
//     - The lookup reads the pre-update counter value and the pre-shift ghr (read-before-write).
//     - This holds even when idx == update_index.
//   Only one counter changes per cycle; all other entries hold.
//   update_valid=0: table and ghr unchanged.
//   The block has no backpressure. Fetch may assert lookup_valid every cycle.
//   The resolution stage guarantees at most one update per cycle.
// TESTING
//   1. reset=0 for 1 edge, then reset=1; lookup pc=0x00 -> next cycle pred_valid=1,
//      prediction=0, pred_index=0, ghr=0.
//   2. With ghr=0, pc=0x10 (idx 4): update idx4 taken x1 -> lookup gives prediction=1.
//      Two more taken updates -> counter stays 11 and ghr shows 1s shifted in. Then one NT
//      update -> prediction=1; second NT -> prediction=0.
//   3. NT updates x3 on idx 7 from reset -> counter saturates at 00; lookup still 0; one
//      taken -> 01, prediction stays 0.
//   4. Hash: drive taken updates to idx 9 so ghr=4'b0011; lookup pc=0x28 (pc idx 10)
//      -> pred_index=10^3=9.
//   5. Same cycle: lookup idx 5 (counter 01) with update idx 5 taken -> prediction=0.
//      Next lookup idx 5 -> 1.
//   6. Reset asserted mid-stream after training several entries -> all lookups return 0,
//      ghr=0, and pred_valid=0 on the reset edge.

Source files
------------

// File: rtl/gshare_pht.sv
// Gshare pattern-history table of 2-bit saturating counters; registered prediction, latency 1.
// No backpressure: a lookup is accepted every cycle, at most one training update per cycle.
module gshare_pht #(
  parameter int PC_W      = 32,
  parameter int IDX_BITS  = 6,
  parameter int HIST_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [PC_W-1:0]      lookup_pc,
  output logic                 pred_valid,
  output logic                 prediction,
  output logic [IDX_BITS-1:0]  pred_index,
  input  logic                 update_valid,
  input  logic [IDX_BITS-1:0]  update_index,
  input  logic                 update_taken,
  output logic [HIST_BITS-1:0] ghr
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]           pht [ENTRIES];
  logic [IDX_BITS-1:0]  lookup_idx;
  logic [1:0]           upd_cnt;
  logic [1:0]           upd_cnt_next;
  logic [HIST_BITS-1:0] ghr_next;

  // The PC's byte-offset bits and anything above the index field never reach the hash.
  generate
    if (PC_W > IDX_BITS + 2) begin : g_pc_hi
      logic unused_pc_bits;
      assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_BITS+2], lookup_pc[1:0]};
    end else begin : g_pc_exact
      logic unused_pc_bits;
      assign unused_pc_bits = ^lookup_pc[1:0];
    end
  endgenerate

  assign lookup_idx = lookup_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);

  always_comb begin
    upd_cnt      = pht[update_index];
    upd_cnt_next = upd_cnt;
    if (update_taken) begin
      if (upd_cnt != 2'b11) upd_cnt_next = upd_cnt + 2'b01;
    end else begin
      if (upd_cnt != 2'b00) upd_cnt_next = upd_cnt - 2'b01;
    end
  end

  generate
    if (HIST_BITS == 1) begin : g_ghr1
      assign ghr_next = update_taken;
    end else begin : g_ghrn
      assign ghr_next = {ghr[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  // Lookup reads pht/ghr before this edge's update lands, even on an index collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
      ghr        <= '0;
      pred_valid <= 1'b0;
      prediction <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_index <= lookup_idx;
        prediction <= pht[lookup_idx][1];
      end
      if (update_valid) begin
        pht[update_index] <= upd_cnt_next;
        ghr               <= ghr_next;
      end
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: directed scenarios plus a random phase, checked through a scoreboard queue.
module tb_gshare_pht;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        prediction;
  logic [5:0]  pred_index;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic [3:0]  ghr;

  gshare_pht #(.PC_W(32), .IDX_BITS(6), .HIST_BITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .prediction   (prediction),
    .pred_index   (pred_index),
    .update_valid (update_valid),
    .update_index (update_index),
    .update_taken (update_taken),
    .ghr          (ghr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pred;
    logic [5:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] m_pht [64];
  logic [3:0] m_ghr;
  logic       last_pred;
  logic [5:0] last_idx;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 2'b01;
    m_ghr     = 4'b0;
    last_pred = 1'b0;
    last_idx  = 6'd0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, push expectation, advance, then check outputs.
  // exp_pred < 0 takes the prediction from the reference model instead of a fixed value.
  task automatic step(input bit lv, input logic [31:0] pc, input int exp_pred,
                      input bit uv, input logic [5:0] ui, input bit ut);
    exp_t e;
    lookup_valid = lv;
    lookup_pc    = pc;
    update_valid = uv;
    update_index = ui;
    update_taken = ut;
    if (lv) begin
      e.idx  = pc[7:2] ^ {2'b00, m_ghr};
      e.pred = (exp_pred < 0) ? m_pht[e.idx][1] : exp_pred[0];
      exp_q.push_back(e);
    end
    if (uv) begin
      if (ut) m_pht[ui] = (m_pht[ui] == 2'b11) ? 2'b11 : m_pht[ui] + 2'b01;
      else    m_pht[ui] = (m_pht[ui] == 2'b00) ? 2'b00 : m_pht[ui] - 2'b01;
      m_ghr = {m_ghr[2:0], ut};
    end
    @(posedge clk);
    #1;
    check("pred_valid", 32'(pred_valid), 32'(lv));
    if (pred_valid) begin
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("prediction", 32'(prediction), 32'(e.pred));
        check("pred_index", 32'(pred_index), 32'(e.idx));
        last_pred = e.pred;
        last_idx  = e.idx;
      end
    end else begin
      check("pred_hold", 32'(prediction), 32'(last_pred));
      check("index_hold", 32'(pred_index), 32'(last_idx));
    end
    check("ghr", 32'(ghr), 32'(m_ghr));
    lookup_valid = 1'b0;
    update_valid = 1'b0;
  endtask

  function automatic logic [31:0] pc_for(input logic [5:0] idx);
    logic [5:0] pci;
    pci = idx ^ {2'b00, m_ghr};
    return {$urandom_range(0, 32'h00FF_FFFF), pci, 2'($urandom_range(0, 3))};
  endfunction

  task automatic lookup(input logic [5:0] idx, input int exp_pred);
    step(1'b1, pc_for(idx), exp_pred, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic train(input logic [5:0] idx, input bit taken);
    step(1'b0, 32'd0, 0, 1'b1, idx, taken);
  endtask

  // Reset edge with a lookup and an update both presented; both must be dropped.
  task automatic do_reset();
    reset        = 1'b0;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h0000_0044;
    update_valid = 1'b1;
    update_index = 6'd3;
    update_taken = 1'b1;
    @(posedge clk);
    #1;
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_prediction", 32'(prediction), 32'd0);
    check("rst_pred_index", 32'(pred_index), 32'd0);
    check("rst_ghr", 32'(ghr), 32'd0);
    reset        = 1'b1;
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    reset        = 1'b1;
    lookup_valid = 1'b0;
    lookup_pc    = 32'd0;
    update_valid = 1'b0;
    update_index = 6'd0;
    update_taken = 1'b0;
    model_reset();
    #2;

    // Reset state and first lookup
    do_reset();
    step(1'b1, 32'h0000_0000, 0, 1'b0, 6'd0, 1'b0);
    check("t1_index0", 32'(pred_index), 32'd0);

    // Saturation upward and back down on idx 4
    train(6'd4, 1'b1);
    lookup(6'd4, 1);
    train(6'd4, 1'b1);
    train(6'd4, 1'b1);
    check("t2_ghr_ones", 32'(ghr), 32'h7);
    lookup(6'd4, 1);
    train(6'd4, 1'b0);
    lookup(6'd4, 1);
    train(6'd4, 1'b0);
    lookup(6'd4, 0);

    // Saturation at strong not-taken on idx 7
    do_reset();
    train(6'd7, 1'b0);
    train(6'd7, 1'b0);
    train(6'd7, 1'b0);
    step(1'b1, 32'h0000_001C, 0, 1'b0, 6'd0, 1'b0);
    check("t3_index7", 32'(pred_index), 32'd7);
    train(6'd7, 1'b1);
    lookup(6'd7, 0);

    // Hash: ghr 0011 with pc index 10 selects entry 9
    do_reset();
    train(6'd9, 1'b1);
    train(6'd9, 1'b1);
    check("t4_ghr", 32'(ghr), 32'h3);
    step(1'b1, 32'h0000_0028, 1, 1'b0, 6'd0, 1'b0);
    check("t4_hash_index", 32'(pred_index), 32'd9);

    // Same-edge lookup and update on the same entry reads the old counter
    do_reset();
    step(1'b1, 32'h0000_0014, 0, 1'b1, 6'd5, 1'b1);
    check("t5_collide_index", 32'(pred_index), 32'd5);
    lookup(6'd5, 1);

    // Mid-stream reset after training several entries
    for (int k = 1; k < 4; k++) begin
      train(6'(k), 1'b1);
      train(6'(k), 1'b1);
    end
    lookup(6'd2, 1);
    do_reset();
    for (int k = 1; k < 6; k++) lookup(6'(k), 0);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), $urandom(), -1,
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (n == 200) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
